csr_chunk_sequencer: RTL and testbench

CSR_CHUNK_SEQUENCER -- requirements
Module: csr_chunk_sequencer

---
 rtl/csr_chunk_sequencer.sv | 85 ++++++++
 tb/tb_csr_chunk_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/csr_chunk_sequencer.sv
// csr_chunk_sequencer: walks a latched CSR row-pointer array chunk by chunk and emits per-chunk row-boundary descriptors
module csr_chunk_sequencer #(
  parameter int N = 16,
  parameter int W = 8,
  localparam int LGN = $clog2(N),
  localparam int PW = 2 * LGN + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [PW-1:0]  ptr [N],
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LGN-1:0] chunk_idx,
  output logic [N-1:0]   elem_valid,
  output logic [N-1:0]   split,
  output logic [LGN-1:0] out_idx [N],
  output logic [N-1:0]   row_done,
  output logic           last,
  output logic           err
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t         state;
  logic [PW-1:0]  ptr_q [N];
  logic [LGN-1:0] k;
  logic [N-1:0]   bad;
  logic [PW-1:0]  nnz, nnz_m1;
  logic           emit, live;
  if (N < 2 || (N & (N - 1)) != 0 || W < 1) begin : g_bad_param
    $error("csr_chunk_sequencer: N must be a power of two >= 2 and W >= 1");
  end
  assign emit = state == EMIT;
  assign nnz = ptr_q[N-1];
  assign nnz_m1 = nnz - PW'(1);
  assign err = |bad || nnz > PW'(N * N);
  assign live = emit && !err;
  assign chunk_idx = emit ? k : '0;
  assign last = emit && ((err || nnz == '0) ? k == '0 : {1'b0, k} == nnz_m1[PW-1:LGN]);
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [PW-1:0] prv, lst;
    if (i == 0) begin : g_first
      assign prv = '0;
    end else begin : g_rest
      assign prv = ptr_q[i-1];
    end
    assign lst = ptr_q[i] - PW'(1);
    assign bad[i] = ptr_q[i] < prv;
    assign row_done[i] = live && ptr_q[i] > prv && lst[PW-1:LGN] == {1'b0, k};
    assign out_idx[i] = row_done[i] ? lst[LGN-1:0] : '0;
    assign elem_valid[i] = live && {1'b0, k, LGN'(i)} < nnz;
  end
  // scatter each finishing row onto the element position where it ends
  always_comb begin
    split = '0;
    for (int r = 0; r < N; r++) if (row_done[r]) split[out_idx[r]] = 1'b1;
  end
  // job acceptance, chunk stepping and handshake state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      k <= '0;
      ptr_q <= '{default: '0};
    end else if (state == IDLE) begin
      if (start) begin
        ptr_q <= ptr;
        k <= '0;
        state <= EMIT;
        in_ready <= 1'b0;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      if (last) begin
        state <= IDLE;
        in_ready <= 1'b1;
        out_valid <= 1'b0;
        k <= '0;
      end else begin
        k <= k + LGN'(1);
      end
    end
  end
endmodule

// File: tb/tb_csr_chunk_sequencer.sv
// tb_csr_chunk_sequencer: vector table plus scoreboard of model descriptors for csr_chunk_sequencer
module tb_csr_chunk_sequencer;
  localparam int N = 16;
  localparam int LGN = 4;
  localparam int PW = 9;
  typedef struct packed {
    logic [N-1:0][PW-1:0] p;
    int                   chunks;
    logic                 err;
  } vec_t;
  typedef struct packed {
    logic [LGN-1:0]          ci;
    logic [N-1:0]            ev;
    logic [N-1:0]            sp;
    logic [N-1:0]            rd;
    logic [N-1:0][LGN-1:0]   oi;
    logic                    last;
  } desc_t;
  logic           clock = 0, reset = 0, start = 0, out_ready = 0;
  logic [PW-1:0]  ptr [N];
  logic           in_ready, out_valid, last, err;
  logic [LGN-1:0] chunk_idx;
  logic [N-1:0]   elem_valid, split, row_done;
  logic [LGN-1:0] out_idx [N];
  vec_t           tbl [8];
  desc_t          q [$];
  int             total = 0, bad = 0;
  csr_chunk_sequencer #(.N(N), .W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .ptr(ptr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .chunk_idx(chunk_idx), .elem_valid(elem_valid), .split(split),
    .out_idx(out_idx), .row_done(row_done), .last(last), .err(err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic desc_t grab();
    desc_t d;
    d.ci = chunk_idx;
    d.ev = elem_valid;
    d.sp = split;
    d.rd = row_done;
    d.last = last;
    for (int r = 0; r < N; r++) d.oi[r] = out_idx[r];
    return d;
  endfunction
  function automatic desc_t model(input logic [N-1:0][PW-1:0] p, input int k, input int nch, input bit e);
    desc_t d;
    int prev, nnz;
    d = '0;
    d.ci = LGN'(k);
    d.last = (k == nch - 1);
    nnz = int'(p[N-1]);
    if (!e) begin
      for (int j = 0; j < N; j++) d.ev[j] = (k * N + j < nnz);
      for (int r = 0; r < N; r++) begin
        prev = (r == 0) ? 0 : int'(p[r-1]);
        if (int'(p[r]) > prev && (int'(p[r]) - 1) / N == k) begin
          d.rd[r] = 1'b1;
          d.oi[r] = LGN'((int'(p[r]) - 1) % N);
          d.sp[(int'(p[r]) - 1) % N] = 1'b1;
        end
      end
    end
    return d;
  endfunction
  task automatic run_job(input int v, input int stall_at, input int rst_at);
    desc_t d;
    int got, cyc, stalls, prev, nch;
    bit done, e;
    for (int j = 0; j < N; j++) ptr[j] = tbl[v].p[j];
    e = int'(tbl[v].p[N-1]) > N * N;
    for (int r = 0; r < N; r++) begin
      prev = (r == 0) ? 0 : int'(tbl[v].p[r-1]);
      if (int'(tbl[v].p[r]) < prev) e = 1;
    end
    nch = (e || tbl[v].p[N-1] == 0) ? 1 : (int'(tbl[v].p[N-1]) + N - 1) / N;
    for (int k = 0; k < nch; k++) q.push_back(model(tbl[v].p, k, nch, e));
    chk($sformatf("v%0d ready_before", v), 64'(in_ready), 64'd1);
    start = 1;
    out_ready = 1;
    @(negedge clock);
    start = 0;
    got = 0; cyc = 0; stalls = 0; done = 0;
    while (!done && cyc < 200) begin
      cyc++;
      if (!out_valid) begin
        chk($sformatf("v%0d out_valid", v), 64'(out_valid), 64'd1);
        break;
      end
      d = grab();
      if (q.size() == 0) begin
        chk($sformatf("v%0d extra_desc", v), 64'(got), 64'(nch));
        break;
      end
      total++;
      if (d !== q[0]) begin
        bad++;
        $display("FAIL v%0d desc k=%0d: got %h expected %h", v, got, d, q[0]);
      end
      chk($sformatf("v%0d err", v), 64'(err), 64'(tbl[v].err));
      if (got == rst_at) begin
        reset = 0;
        @(negedge clock);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst err", 64'(err), 64'd0);
        total++;
        if (grab() !== '0) begin
          bad++;
          $display("FAIL rst desc: got %h expected 0", grab());
        end
        reset = 1;
        q.delete();
        return;
      end
      if (got == stall_at && stalls < 3) begin
        out_ready = 0;
        start = 1;
        stalls++;
      end else begin
        out_ready = 1;
        start = 0;
        void'(q.pop_front());
        got++;
        done = d.last;
      end
      @(negedge clock);
    end
    start = 0;
    if (cyc >= 200) chk($sformatf("v%0d timeout", v), 64'(cyc), 64'd0);
    chk($sformatf("v%0d chunks", v), 64'(got), 64'(tbl[v].chunks));
    chk($sformatf("v%0d ready_after", v), 64'(in_ready), 64'd1);
    chk($sformatf("v%0d valid_after", v), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d idx_after", v), 64'(chunk_idx), 64'd0);
    q.delete();
  endtask
  initial begin
    for (int j = 0; j < N; j++) begin
      ptr[j] = '0;
      tbl[0].p[j] = PW'(j + 1);
      tbl[1].p[j] = PW'(16 * (j + 1));
      tbl[2].p[j] = PW'(20);
      tbl[3].p[j] = '0;
      tbl[4].p[j] = PW'(j + 3);
      tbl[5].p[j] = PW'(j);
      tbl[6].p[j] = PW'(7 * ((j + 1) / 3));
      tbl[7].p[j] = (j < 8) ? PW'(0) : PW'(256);
    end
    tbl[4].p[4] = PW'(7);
    tbl[4].p[5] = PW'(3);
    tbl[5].p[15] = PW'(257);
    tbl[0].chunks = 1;  tbl[0].err = 0;
    tbl[1].chunks = 16; tbl[1].err = 0;
    tbl[2].chunks = 2;  tbl[2].err = 0;
    tbl[3].chunks = 1;  tbl[3].err = 0;
    tbl[4].chunks = 1;  tbl[4].err = 1;
    tbl[5].chunks = 1;  tbl[5].err = 1;
    tbl[6].chunks = 3;  tbl[6].err = 0;
    tbl[7].chunks = 16; tbl[7].err = 0;
    repeat (2) @(negedge clock);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset last", 64'(last), 64'd0);
    chk("reset chunk_idx", 64'(chunk_idx), 64'd0);
    reset = 1;
    @(negedge clock);
    for (int v = 0; v < 8; v++) run_job(v, -1, -1);
    run_job(1, 4, -1);
    run_job(1, -1, 5);
    @(negedge clock);
    run_job(0, -1, -1);
    for (int j = 0; j < N; j++) ptr[j] = PW'(20);
    start = 1;
    out_ready = 1;
    @(negedge clock);
    start = 0;
    chk("h20 c0 split", 64'(split), 64'h0);
    chk("h20 c0 elem_valid", 64'(elem_valid), 64'hffff);
    chk("h20 c0 row_done", 64'(row_done), 64'h0);
    chk("h20 c0 last", 64'(last), 64'd0);
    @(negedge clock);
    chk("h20 c1 split", 64'(split), 64'h0008);
    chk("h20 c1 elem_valid", 64'(elem_valid), 64'h000f);
    chk("h20 c1 row_done", 64'(row_done), 64'h0001);
    chk("h20 c1 out_idx0", 64'(out_idx[0]), 64'd3);
    chk("h20 c1 last", 64'(last), 64'd1);
    @(negedge clock);
    chk("h20 in_ready", 64'(in_ready), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
